// File: rtl/reorder_buffer_pkg.sv
// Shared constants for the reorder buffer: default geometry and instruction kind encodings.
package reorder_buffer_pkg;
  localparam int ROB_DEPTH_DEF = 16;
  localparam int ROB_XLEN_DEF  = 32;
  localparam int RD_W          = 5;

  typedef enum logic [1:0] {
    KIND_ALU   = 2'd0,
    KIND_LOAD  = 2'd1,
    KIND_STORE = 2'd2
  } kind_e;
endpackage

// File: rtl/rob_src_lookup.sv
// Operand readiness/value lookup with same-cycle writeback bypass (ALU beats load beats stored).
module rob_src_lookup #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input  logic             tag_valid,
  input  logic [TAG_W-1:0] tag,
  input  logic             entry_done,
  input  logic [XLEN-1:0]  entry_value,
  input  logic             alu_valid,
  input  logic [TAG_W-1:0] alu_tag,
  input  logic [XLEN-1:0]  alu_value,
  input  logic             lsb_valid,
  input  logic [TAG_W-1:0] lsb_tag,
  input  logic [XLEN-1:0]  lsb_value,
  output logic             ready,
  output logic [XLEN-1:0]  value
);
  always_comb begin
    ready = 1'b0;
    value = '0;
    if (!tag_valid) begin
      ready = 1'b1;
    end else if (alu_valid && alu_tag == tag) begin
      ready = 1'b1;
      value = alu_value;
    end else if (lsb_valid && lsb_tag == tag) begin
      ready = 1'b1;
      value = lsb_value;
    end else if (entry_done) begin
      ready = 1'b1;
      value = entry_value;
    end
  end
endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer with operand forwarding, store commit handshake and mispredict flush.
// Optional macro ROB_PERF_CNT_EN adds retirement/flush counters on perf_commit_cnt/perf_flush_cnt.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH_DEF,
  parameter int XLEN  = ROB_XLEN_DEF,
  localparam int TAG_W = $clog2(DEPTH),
  localparam int CNT_W = TAG_W + 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             disp_valid,
  input  logic [1:0]       disp_kind,
  input  logic [RD_W-1:0]  disp_rd,
  input  logic [XLEN-1:0]  disp_pred_npc,
  output logic [TAG_W-1:0] disp_tag,
  output logic             rob_full,
  input  logic             alu_wb_valid,
  input  logic [TAG_W-1:0] alu_wb_tag,
  input  logic [XLEN-1:0]  alu_wb_value,
  input  logic [XLEN-1:0]  alu_wb_npc,
  input  logic             lsb_wb_valid,
  input  logic [TAG_W-1:0] lsb_wb_tag,
  input  logic [XLEN-1:0]  lsb_wb_value,
  input  logic             src1_tag_valid,
  input  logic [TAG_W-1:0] src1_tag,
  output logic             src1_ready,
  output logic [XLEN-1:0]  src1_value,
  input  logic             src2_tag_valid,
  input  logic [TAG_W-1:0] src2_tag,
  output logic             src2_ready,
  output logic [XLEN-1:0]  src2_value,
  output logic             cmt_valid,
  output logic [RD_W-1:0]  cmt_rd,
  output logic [XLEN-1:0]  cmt_value,
  output logic [TAG_W-1:0] cmt_tag,
  output logic [TAG_W-1:0] head_tag,
  output logic             st_commit_req,
  output logic [TAG_W-1:0] st_commit_tag,
  input  logic             st_commit_ack,
  output logic             flush,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [31:0]      perf_commit_cnt,
  output logic [31:0]      perf_flush_cnt
);
  logic             busy_q  [DEPTH];
  logic             done_q  [DEPTH];
  kind_e            kind_q  [DEPTH];
  logic [RD_W-1:0]  rd_q    [DEPTH];
  logic [XLEN-1:0]  value_q [DEPTH];
  logic [XLEN-1:0]  pred_q  [DEPTH];
  logic [XLEN-1:0]  act_q   [DEPTH];
  logic [TAG_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q;
  logic head_store, alu_retire, st_retire, retire, mispredict;
  logic wb_en, alu_wb_en, lsb_wb_en, disp_fire;

  assign rob_full      = (count_q == CNT_W'(DEPTH));
  assign disp_tag      = tail_q;
  assign head_tag      = head_q;
  assign st_commit_tag = head_q;

  // Store handshake: st_commit_req stays high while the head is a busy store;
  // the store retires in the cycle where req and ack are both high. Ack alone is ignored.
  assign head_store    = busy_q[head_q] && (kind_q[head_q] == KIND_STORE);
  assign st_commit_req = rdy_in && head_store;
  assign st_retire     = st_commit_req && st_commit_ack;
  assign alu_retire    = rdy_in && busy_q[head_q] && done_q[head_q] && !head_store;
  assign retire        = alu_retire || st_retire;
  assign mispredict    = retire && (act_q[head_q] != pred_q[head_q]);

  // Nothing new is accepted while the buffer is being discarded or the redirect is out.
  assign wb_en     = rdy_in && !flush && !mispredict;
  assign alu_wb_en = wb_en && alu_wb_valid;
  assign lsb_wb_en = wb_en && lsb_wb_valid;
  assign disp_fire = rdy_in && disp_valid && !rob_full && !flush && !mispredict;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        busy_q[i] <= 1'b0;
        done_q[i] <= 1'b0;
      end
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      cmt_valid   <= 1'b0;
      cmt_rd      <= '0;
      cmt_value   <= '0;
      cmt_tag     <= '0;
      flush       <= 1'b0;
      redirect_pc <= '0;
    end else if (!rdy_in) begin
      cmt_valid <= 1'b0;
      flush     <= 1'b0;
    end else begin
      cmt_valid <= retire;
      flush     <= mispredict;
      if (retire) begin
        cmt_rd    <= head_store ? '0 : rd_q[head_q];
        cmt_value <= value_q[head_q];
        cmt_tag   <= head_q;
      end
      if (mispredict) begin
        for (int i = 0; i < DEPTH; i++) begin
          busy_q[i] <= 1'b0;
          done_q[i] <= 1'b0;
        end
        head_q      <= '0;
        tail_q      <= '0;
        count_q     <= '0;
        redirect_pc <= act_q[head_q];
      end else begin
        // ALU written last so it wins a same-tag collision with the load port.
        if (lsb_wb_en && busy_q[lsb_wb_tag]) begin
          value_q[lsb_wb_tag] <= lsb_wb_value;
          done_q[lsb_wb_tag]  <= 1'b1;
        end
        if (alu_wb_en && busy_q[alu_wb_tag]) begin
          value_q[alu_wb_tag] <= alu_wb_value;
          act_q[alu_wb_tag]   <= alu_wb_npc;
          done_q[alu_wb_tag]  <= 1'b1;
        end
        if (retire) begin
          busy_q[head_q] <= 1'b0;
          done_q[head_q] <= 1'b0;
          head_q         <= head_q + TAG_W'(1);
        end
        if (disp_fire) begin
          busy_q[tail_q]  <= 1'b1;
          done_q[tail_q]  <= 1'b0;
          kind_q[tail_q]  <= kind_e'(disp_kind);
          rd_q[tail_q]    <= disp_rd;
          value_q[tail_q] <= '0;
          pred_q[tail_q]  <= disp_pred_npc;
          act_q[tail_q]   <= disp_pred_npc;
          tail_q          <= tail_q + TAG_W'(1);
        end
        case ({disp_fire, retire})
          2'b10:   count_q <= count_q + CNT_W'(1);
          2'b01:   count_q <= count_q - CNT_W'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

  rob_src_lookup #(.XLEN(XLEN), .TAG_W(TAG_W)) u_src1 (
    .tag_valid   (src1_tag_valid),
    .tag         (src1_tag),
    .entry_done  (done_q[src1_tag]),
    .entry_value (value_q[src1_tag]),
    .alu_valid   (alu_wb_en),
    .alu_tag     (alu_wb_tag),
    .alu_value   (alu_wb_value),
    .lsb_valid   (lsb_wb_en),
    .lsb_tag     (lsb_wb_tag),
    .lsb_value   (lsb_wb_value),
    .ready       (src1_ready),
    .value       (src1_value)
  );

  rob_src_lookup #(.XLEN(XLEN), .TAG_W(TAG_W)) u_src2 (
    .tag_valid   (src2_tag_valid),
    .tag         (src2_tag),
    .entry_done  (done_q[src2_tag]),
    .entry_value (value_q[src2_tag]),
    .alu_valid   (alu_wb_en),
    .alu_tag     (alu_wb_tag),
    .alu_value   (alu_wb_value),
    .lsb_valid   (lsb_wb_en),
    .lsb_tag     (lsb_wb_tag),
    .lsb_value   (lsb_wb_value),
    .ready       (src2_ready),
    .value       (src2_value)
  );

`ifdef ROB_PERF_CNT_EN
  logic [31:0] commit_cnt_q, flush_cnt_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      commit_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else if (rdy_in) begin
      if (retire)     commit_cnt_q <= commit_cnt_q + 32'd1;
      if (mispredict) flush_cnt_q  <= flush_cnt_q + 32'd1;
    end
  end

  assign perf_commit_cnt = commit_cnt_q;
  assign perf_flush_cnt  = flush_cnt_q;
`else
  assign perf_commit_cnt = '0;
  assign perf_flush_cnt  = '0;
`endif
endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed corner sequences, a bypass vector table and random traffic vs a queue model.
module tb_reorder_buffer;
  localparam int DEPTH = 16;
  localparam int XLEN  = 32;
  localparam int TAG_W = 4;

  logic             clk_in = 1'b0;
  logic             rst_in, rdy_in;
  logic             disp_valid;
  logic [1:0]       disp_kind;
  logic [4:0]       disp_rd;
  logic [XLEN-1:0]  disp_pred_npc;
  logic [TAG_W-1:0] disp_tag;
  logic             rob_full;
  logic             alu_wb_valid;
  logic [TAG_W-1:0] alu_wb_tag;
  logic [XLEN-1:0]  alu_wb_value, alu_wb_npc;
  logic             lsb_wb_valid;
  logic [TAG_W-1:0] lsb_wb_tag;
  logic [XLEN-1:0]  lsb_wb_value;
  logic             src1_tag_valid, src2_tag_valid;
  logic [TAG_W-1:0] src1_tag, src2_tag;
  logic             src1_ready, src2_ready;
  logic [XLEN-1:0]  src1_value, src2_value;
  logic             cmt_valid;
  logic [4:0]       cmt_rd;
  logic [XLEN-1:0]  cmt_value;
  logic [TAG_W-1:0] cmt_tag, head_tag;
  logic             st_commit_req, st_commit_ack;
  logic [TAG_W-1:0] st_commit_tag;
  logic             flush;
  logic [XLEN-1:0]  redirect_pc;
  logic [31:0]      perf_commit_cnt, perf_flush_cnt;

  always #5 clk_in = ~clk_in;

  reorder_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .disp_valid(disp_valid), .disp_kind(disp_kind), .disp_rd(disp_rd),
    .disp_pred_npc(disp_pred_npc), .disp_tag(disp_tag), .rob_full(rob_full),
    .alu_wb_valid(alu_wb_valid), .alu_wb_tag(alu_wb_tag), .alu_wb_value(alu_wb_value),
    .alu_wb_npc(alu_wb_npc),
    .lsb_wb_valid(lsb_wb_valid), .lsb_wb_tag(lsb_wb_tag), .lsb_wb_value(lsb_wb_value),
    .src1_tag_valid(src1_tag_valid), .src1_tag(src1_tag), .src1_ready(src1_ready),
    .src1_value(src1_value),
    .src2_tag_valid(src2_tag_valid), .src2_tag(src2_tag), .src2_ready(src2_ready),
    .src2_value(src2_value),
    .cmt_valid(cmt_valid), .cmt_rd(cmt_rd), .cmt_value(cmt_value), .cmt_tag(cmt_tag),
    .head_tag(head_tag),
    .st_commit_req(st_commit_req), .st_commit_tag(st_commit_tag), .st_commit_ack(st_commit_ack),
    .flush(flush), .redirect_pc(redirect_pc),
    .perf_commit_cnt(perf_commit_cnt), .perf_flush_cnt(perf_flush_cnt)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: program-order queue of live entries ----------------
  typedef struct {
    int          kind;
    int          rd;
    logic [31:0] pred;
    logic [31:0] act;
    logic [31:0] value;
    bit          done;
    int          tag;
  } ent_t;

  ent_t        mq[$];
  int          m_tail;
  bit          m_flush;
  bit          e_cmt_valid, e_flush;
  int          e_cmt_rd, e_cmt_tag;
  logic [31:0] e_cmt_value, e_redirect;
  int          m_commits, m_flushes;
  logic [TAG_W-1:0] exp_q[$];
  int          wrap_seen;

  task automatic model_reset();
    mq.delete();
    m_tail = 0; m_flush = 0;
    e_cmt_valid = 0; e_flush = 0; e_cmt_rd = 0; e_cmt_tag = 0;
    e_cmt_value = 0; e_redirect = 0;
    m_commits = 0; m_flushes = 0;
  endtask

  function automatic void src_model(input logic tv, input logic [TAG_W-1:0] tag, input bit wb_en,
                                    output logic rdy, output logic [31:0] val);
    rdy = 1'b0;
    val = '0;
    if (!tv) begin
      rdy = 1'b1;
    end else if (wb_en && alu_wb_valid && alu_wb_tag == tag) begin
      rdy = 1'b1; val = alu_wb_value;
    end else if (wb_en && lsb_wb_valid && lsb_wb_tag == tag) begin
      rdy = 1'b1; val = lsb_wb_value;
    end else begin
      foreach (mq[i]) if (mq[i].tag == int'(tag) && mq[i].done) begin
        rdy = 1'b1; val = mq[i].value;
      end
    end
  endfunction

  task automatic idle_inputs();
    rdy_in = 1'b1;
    disp_valid = 1'b0; disp_kind = 2'd0; disp_rd = 5'd0; disp_pred_npc = '0;
    alu_wb_valid = 1'b0; alu_wb_tag = '0; alu_wb_value = '0; alu_wb_npc = '0;
    lsb_wb_valid = 1'b0; lsb_wb_tag = '0; lsb_wb_value = '0;
    src1_tag_valid = 1'b0; src1_tag = '0; src2_tag_valid = 1'b0; src2_tag = '0;
    st_commit_ack = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    model_reset();
  endtask

  // One clock: check combinational outputs against the model, advance the model, check registered outputs.
  task automatic cycle();
    bit retire, mis, wb_en, full;
    int head;
    logic r1, r2;
    logic [31:0] v1, v2;
    ent_t e;
    #1;
    full = (mq.size() == DEPTH);
    head = (mq.size() > 0) ? mq[0].tag : m_tail;
    retire = 0;
    mis = 0;
    if (mq.size() > 0) begin
      retire = (mq[0].kind == 2) ? bit'(st_commit_ack) : mq[0].done;
      mis = retire && (mq[0].act != mq[0].pred);
    end
    wb_en = !m_flush && !mis;
    check("rob_full", rob_full, full);
    check("disp_tag", disp_tag, m_tail);
    check("head_tag", head_tag, head);
    check("st_commit_req", st_commit_req, (mq.size() > 0) && (mq[0].kind == 2));
    check("st_commit_tag", st_commit_tag, head);
    src_model(src1_tag_valid, src1_tag, wb_en, r1, v1);
    src_model(src2_tag_valid, src2_tag, wb_en, r2, v2);
    check("src1_ready", src1_ready, r1);
    check("src1_value", src1_value, v1);
    check("src2_ready", src2_ready, r2);
    check("src2_value", src2_value, v2);

    e_cmt_valid = 0;
    e_flush = 0;
    if (retire) begin
      e_cmt_valid = 1;
      e_cmt_rd    = (mq[0].kind == 2) ? 0 : mq[0].rd;
      e_cmt_value = mq[0].value;
      e_cmt_tag   = mq[0].tag;
      m_commits++;
    end
    if (mis) begin
      e_flush = 1;
      e_redirect = mq[0].act;
      mq.delete();
      m_tail = 0;
      m_flushes++;
    end else begin
      if (wb_en && lsb_wb_valid)
        foreach (mq[i]) if (mq[i].tag == int'(lsb_wb_tag)) begin
          mq[i].value = lsb_wb_value; mq[i].done = 1;
        end
      if (wb_en && alu_wb_valid)
        foreach (mq[i]) if (mq[i].tag == int'(alu_wb_tag)) begin
          mq[i].value = alu_wb_value; mq[i].act = alu_wb_npc; mq[i].done = 1;
        end
      if (retire) void'(mq.pop_front());
      if (disp_valid && !full && !m_flush) begin
        e.kind = int'(disp_kind); e.rd = int'(disp_rd);
        e.pred = disp_pred_npc; e.act = disp_pred_npc;
        e.value = '0; e.done = 0; e.tag = m_tail;
        mq.push_back(e);
        m_tail = (m_tail + 1) % DEPTH;
      end
    end
    m_flush = e_flush;

    @(posedge clk_in); #1;
    check("cmt_valid", cmt_valid, e_cmt_valid);
    if (e_cmt_valid) begin
      check("cmt_rd", cmt_rd, e_cmt_rd);
      check("cmt_value", cmt_value, e_cmt_value);
      check("cmt_tag", cmt_tag, e_cmt_tag);
    end
    check("flush", flush, e_flush);
    if (e_flush) check("redirect_pc", redirect_pc, e_redirect);
    if (cmt_valid === 1'b1 && exp_q.size() > 0) begin
      check("wrap_cmt_tag", cmt_tag, exp_q.pop_front());
      wrap_seen++;
    end
  endtask

  task automatic dispatch(input int kind, input int rd, input logic [31:0] pred);
    disp_valid = 1'b1; disp_kind = 2'(kind); disp_rd = 5'(rd); disp_pred_npc = pred;
    cycle();
    disp_valid = 1'b0;
  endtask

  // Bypass/forwarding vectors applied combinationally against a fixed buffer state.
  typedef struct {
    logic        tv;
    logic [3:0]  tag;
    logic        av;
    logic [3:0]  at;
    logic [31:0] aval;
    logic        lv;
    logic [3:0]  lt;
    logic [31:0] lval;
    logic        e_rdy;
    logic [31:0] e_val;
  } bvec_t;

  bvec_t bt[10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bt[0] = '{1'b0, 4'd5,  1'b0, 4'd0, 32'h0,      1'b0, 4'd0, 32'h0,      1'b1, 32'h0};
    bt[1] = '{1'b1, 4'd5,  1'b0, 4'd0, 32'h0,      1'b0, 4'd0, 32'h0,      1'b0, 32'h0};
    bt[2] = '{1'b1, 4'd5,  1'b1, 4'd5, 32'hDEAD,   1'b0, 4'd0, 32'h0,      1'b1, 32'hDEAD};
    bt[3] = '{1'b1, 4'd5,  1'b0, 4'd0, 32'h0,      1'b1, 4'd5, 32'hBEEF,   1'b1, 32'hBEEF};
    bt[4] = '{1'b1, 4'd5,  1'b1, 4'd5, 32'hDEAD,   1'b1, 4'd5, 32'hBEEF,   1'b1, 32'hDEAD};
    bt[5] = '{1'b1, 4'd2,  1'b0, 4'd0, 32'h0,      1'b0, 4'd0, 32'h0,      1'b1, 32'h2222};
    bt[6] = '{1'b1, 4'd3,  1'b0, 4'd0, 32'h0,      1'b0, 4'd0, 32'h0,      1'b1, 32'h3333};
    bt[7] = '{1'b1, 4'd2,  1'b1, 4'd2, 32'h9999,   1'b0, 4'd0, 32'h0,      1'b1, 32'h9999};
    bt[8] = '{1'b1, 4'd6,  1'b1, 4'd5, 32'hDEAD,   1'b0, 4'd0, 32'h0,      1'b0, 32'h0};
    bt[9] = '{1'b1, 4'd12, 1'b0, 4'd0, 32'h0,      1'b0, 4'd0, 32'h0,      1'b0, 32'h0};
    wrap_seen = 0;

    // Reset values
    do_reset();
    check("rst_cmt_valid", cmt_valid, 0);
    check("rst_cmt_rd", cmt_rd, 0);
    check("rst_cmt_value", cmt_value, 0);
    check("rst_cmt_tag", cmt_tag, 0);
    check("rst_flush", flush, 0);
    check("rst_redirect_pc", redirect_pc, 0);
    check("rst_rob_full", rob_full, 0);
    check("rst_disp_tag", disp_tag, 0);
    check("rst_head_tag", head_tag, 0);
    check("rst_st_commit_req", st_commit_req, 0);

    // Global enable low: dispatch is not taken
    rdy_in = 1'b0; disp_valid = 1'b1;
    @(posedge clk_in); #1;
    check("rdy_low_tail_hold", disp_tag, 0);
    check("rdy_low_cmt_valid", cmt_valid, 0);
    idle_inputs();

    // Ack with no request is ignored
    st_commit_ack = 1'b1;
    cycle();
    st_commit_ack = 1'b0;

    // Fill: 16 dispatches, 17th ignored
    for (int i = 0; i < 16; i++) dispatch(0, i + 1, 32'h1000 + 32'(4 * i));
    check("fill_full", rob_full, 1);
    dispatch(0, 30, 32'h5000);
    check("fill_tail_hold", disp_tag, 0);
    check("fill_still_full", rob_full, 1);

    // Full buffer: head retires while a dispatch is offered -> rejected, count 15
    alu_wb_valid = 1'b1; alu_wb_tag = 4'd0; alu_wb_value = 32'h55; alu_wb_npc = 32'h1000;
    cycle();
    alu_wb_valid = 1'b0;
    dispatch(0, 31, 32'h6000);
    check("simul_not_full", rob_full, 0);
    check("simul_tail_hold", disp_tag, 0);
    check("simul_head_adv", head_tag, 1);
    dispatch(0, 29, 32'h6004);
    check("simul_count15_refill", rob_full, 1);

    // Forwarding table
    do_reset();
    for (int i = 0; i < 8; i++) dispatch((i == 3) ? 1 : 0, i + 1, 32'h100 + 32'(4 * i));
    alu_wb_valid = 1'b1; alu_wb_tag = 4'd2; alu_wb_value = 32'h2222; alu_wb_npc = 32'h108;
    cycle();
    alu_wb_valid = 1'b0;
    lsb_wb_valid = 1'b1; lsb_wb_tag = 4'd3; lsb_wb_value = 32'h3333;
    cycle();
    lsb_wb_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      src1_tag_valid = bt[i].tv; src1_tag = bt[i].tag;
      src2_tag_valid = bt[i].tv; src2_tag = bt[i].tag;
      alu_wb_valid = bt[i].av; alu_wb_tag = bt[i].at; alu_wb_value = bt[i].aval;
      alu_wb_npc = 32'h100 + 32'(4 * int'(bt[i].at));
      lsb_wb_valid = bt[i].lv; lsb_wb_tag = bt[i].lt; lsb_wb_value = bt[i].lval;
      #1;
      check($sformatf("bypass%0d_src1_ready", i), src1_ready, bt[i].e_rdy);
      check($sformatf("bypass%0d_src1_value", i), src1_value, bt[i].e_val);
      check($sformatf("bypass%0d_src2_ready", i), src2_ready, bt[i].e_rdy);
      check($sformatf("bypass%0d_src2_value", i), src2_value, bt[i].e_val);
      alu_wb_valid = 1'b0; lsb_wb_valid = 1'b0;
      src1_tag_valid = 1'b0; src2_tag_valid = 1'b0;
      @(posedge clk_in); #1;
    end

    // Mispredict at commit
    do_reset();
    dispatch(0, 3, 32'h104);
    dispatch(0, 4, 32'h108);
    alu_wb_valid = 1'b1; alu_wb_tag = 4'd0; alu_wb_value = 32'h77; alu_wb_npc = 32'h200;
    cycle();
    alu_wb_tag = 4'd1; alu_wb_npc = 32'h108;
    disp_valid = 1'b1; disp_pred_npc = 32'h300;
    cycle();
    check("mis_flush", flush, 1);
    check("mis_redirect", redirect_pc, 32'h200);
    check("mis_count0", rob_full, 0);
    check("mis_disp_tag0", disp_tag, 0);
    check("mis_head_tag0", head_tag, 0);
    cycle();
    alu_wb_valid = 1'b0; disp_valid = 1'b0;
    check("flush_drop_disp", disp_tag, 0);
    check("flush_pulse_end", flush, 0);
    dispatch(0, 5, 32'h200);
    check("post_flush_disp", disp_tag, 1);

    // Store handshake with delayed ack
    do_reset();
    dispatch(2, 9, 32'h400);
    check("st_req", st_commit_req, 1);
    check("st_tag", st_commit_tag, 0);
    for (int i = 0; i < 3; i++) cycle();
    st_commit_ack = 1'b1;
    cycle();
    st_commit_ack = 1'b0;
    check("st_cmt_valid", cmt_valid, 1);
    check("st_cmt_rd0", cmt_rd, 0);
    check("st_head_adv", head_tag, 1);

    // Reset in the middle of a store handshake
    dispatch(2, 7, 32'h500);
    check("st2_req", st_commit_req, 1);
    do_reset();
    check("rst_abandon_store", st_commit_req, 0);

    // Wrap: 20 ALU ops in order
    for (int k = 0; k < 20; k++) exp_q.push_back(TAG_W'(k % DEPTH));
    wrap_seen = 0;
    for (int i = 0; i < 60 && exp_q.size() > 0; i++) begin
      disp_valid = (i < 20);
      disp_kind = 2'd0; disp_rd = 5'((i % 31) + 1); disp_pred_npc = 32'h2000 + 32'(4 * i);
      alu_wb_valid = (i >= 1 && i <= 20);
      alu_wb_tag = TAG_W'((i - 1) % DEPTH);
      alu_wb_value = 32'hA000 + 32'(i - 1);
      alu_wb_npc = 32'h2000 + 32'(4 * (i - 1));
      cycle();
    end
    idle_inputs();
    check("wrap_commit_cnt", wrap_seen, 20);
    exp_q.delete();

    // Random traffic vs model
    do_reset();
    for (int c = 0; c < 800; c++) begin
      int alu_c[$];
      int lsb_c[$];
      idle_inputs();
      disp_valid = ($urandom_range(0, 3) != 0);
      disp_kind = 2'($urandom_range(0, 2));
      disp_rd = 5'($urandom_range(1, 31));
      disp_pred_npc = 32'($urandom_range(0, 4095)) << 2;
      foreach (mq[i]) if (!mq[i].done && mq[i].kind == 0) alu_c.push_back(i);
      foreach (mq[i]) if (!mq[i].done && mq[i].kind == 1) lsb_c.push_back(i);
      if (alu_c.size() > 0 && $urandom_range(0, 1) == 1) begin
        int j;
        j = alu_c[$urandom_range(0, alu_c.size() - 1)];
        alu_wb_valid = 1'b1;
        alu_wb_tag = TAG_W'(mq[j].tag);
        alu_wb_value = $urandom;
        alu_wb_npc = ($urandom_range(0, 15) == 0) ? mq[j].pred + 32'd4 : mq[j].pred;
      end
      if (lsb_c.size() > 0 && $urandom_range(0, 1) == 1) begin
        int j;
        j = lsb_c[$urandom_range(0, lsb_c.size() - 1)];
        lsb_wb_valid = 1'b1;
        lsb_wb_tag = TAG_W'(mq[j].tag);
        lsb_wb_value = $urandom;
      end
      st_commit_ack = ($urandom_range(0, 2) == 0);
      src1_tag_valid = $urandom_range(0, 1) == 1; src1_tag = TAG_W'($urandom_range(0, DEPTH - 1));
      src2_tag_valid = $urandom_range(0, 1) == 1; src2_tag = TAG_W'($urandom_range(0, DEPTH - 1));
      cycle();
    end
    idle_inputs();

`ifdef ROB_PERF_CNT_EN
    check("perf_commit_cnt", perf_commit_cnt, m_commits);
    check("perf_flush_cnt", perf_flush_cnt, m_flushes);
`else
    check("perf_commit_tied", perf_commit_cnt, 0);
    check("perf_flush_tied", perf_flush_cnt, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, entry count; power of two, 4..64.
REQ-002 SHALL have parameter XLEN, default 32, data and address width.
REQ-003 SHALL derive localparam TAG_W = log2(DEPTH); tags run 0..DEPTH-1, and a separate valid bit marks "no dependency".
REQ-004 SHALL have a single clock and a synchronous active-high reset: clk_in  in  1  clock; rst_in  in  1  sync active-high reset.
REQ-005 SHALL have rdy_in  in  1  global enable; when low, all state holds and pulse outputs are 0.
REQ-006 SHALL have the dispatch port: disp_valid in 1; disp_kind in 2 (0 ALU, 1 load, 2 store); disp_rd in 5; disp_pred_npc in XLEN; disp_tag out TAG_W (tail); rob_full out 1.
REQ-007 SHALL have the ALU writeback port: alu_wb_valid in 1; alu_wb_tag in TAG_W; alu_wb_value in XLEN; alu_wb_npc in XLEN.
REQ-008 SHALL have the load writeback port: lsb_wb_valid in 1; lsb_wb_tag in TAG_W; lsb_wb_value in XLEN.
REQ-009 SHALL have, per operand n=1,2: srcN_tag_valid in 1; srcN_tag in TAG_W; srcN_ready out 1; srcN_value out XLEN.
REQ-010 SHALL have the commit port: cmt_valid out 1; cmt_rd out 5; cmt_value out XLEN; cmt_tag out TAG_W; head_tag out TAG_W.
REQ-011 SHALL have the store handshake: st_commit_req out 1; st_commit_tag out TAG_W; st_commit_ack in 1.
REQ-012 SHALL have the flush outputs: flush out 1; redirect_pc out XLEN.

Function
REQ-013 SHALL keep head, tail (TAG_W bits, natural wrap) and count (TAG_W+1 bits); rob_full = (count == DEPTH), combinational from registered count.
REQ-014 SHALL accept disp_valid && !rob_full && !flush at the edge: entry[tail] is written busy=1, done=0, and actual npc initialised to disp_pred_npc; tail increments.
REQ-015 SHALL, on ALU writeback, set value, actual npc and done=1 for the tagged entry; on load writeback, set value and done=1.
REQ-016 SHALL have the ALU port win when both writeback ports carry the same tag in one cycle; this is a protocol violation.
REQ-017 SHALL drive srcN_ready=1 when !srcN_tag_valid, when entry done, or when a same-cycle writeback matches the tag (bypass, ALU priority); srcN_value follows the same priority, else 0.
REQ-018 SHALL commit when head entry is busy, done and kind != store: next cycle cmt_valid=1 with cmt_rd/cmt_value/cmt_tag registered; head increments; entry cleared.
REQ-019 SHALL drive, while head is a busy store, st_commit_req=1 combinationally with st_commit_tag=head; on st_commit_ack the entry retires (head++) and cmt_valid pulses with cmt_rd=0.
REQ-020 SHALL treat st_commit_ack without st_commit_req as ignored.
REQ-021 SHALL, at commit with actual npc != predicted npc, clear all entries and set head=tail=count=0 at that same edge; the next cycle has flush=1 for one cycle and redirect_pc=actual npc.
REQ-022 SHALL drop dispatch and writebacks arriving in the mispredict-commit cycle or the flush-high cycle.
REQ-023 SHALL update count by +1 on dispatch only, -1 on retire only, and leave it unchanged on both; a dispatch with rob_full=1 is ignored even if a retire occurs that cycle.
REQ-024 SHALL retire at most one entry per cycle.

Reset
REQ-025 SHALL, on rst_in at the edge, clear all entries, head=tail=count=0, and drive cmt_valid=0, cmt_rd=0, cmt_value=0, cmt_tag=0, flush=0, redirect_pc=0; rst_in overrides rdy_in.
REQ-026 SHALL abandon any in-flight store handshake on reset mid-operation; st_commit_req=0 the following cycle.

Configuration
REQ-027 SHALL support macro ROB_PERF_CNT_EN: when defined, outputs perf_commit_cnt and perf_flush_cnt (32 bits, reset 0, wrapping) count retirements and flushes.
REQ-028 SHALL, without ROB_PERF_CNT_EN, keep the perf_commit_cnt and perf_flush_cnt ports but tie them to 0 and instantiate no counter logic.

Structure
REQ-029 SHALL place the kind encodings (KIND_ALU/KIND_LOAD/KIND_STORE) and the default DEPTH/XLEN in the shared constants file.
REQ-030 SHALL implement the forwarding lookup of REQ-017 as one sub-module, rob_src_lookup, instantiated twice.

Verification
REQ-031 SHALL cover fill: 16 dispatches with no writeback -> rob_full=1 after the 16th, and the 17th is ignored with tail unchanged.
REQ-032 SHALL cover wrap: 20 ALU ops dispatched and written back in order -> 20 cmt_valid pulses, cmt_tag sequence 0..15,0..3.
REQ-033 SHALL cover bypass: src1_tag=5 valid, alu_wb tag 5 value 0xDEAD same cycle -> src1_ready=1, src1_value=0xDEAD.
REQ-034 SHALL cover mispredict: head pred_npc 0x104, alu_wb_npc 0x200 -> next cycle flush=1, redirect_pc=0x200, count=0, disp_tag=0.
REQ-035 SHALL cover store: store at head done=0 -> st_commit_req=1 with st_commit_tag=head; ack after 3 cycles -> head++, cmt_valid with cmt_rd=0.
REQ-036 SHALL cover simultaneous: full buffer, head retires and disp_valid=1 in the same cycle -> dispatch rejected, count=15.
